uart_char_rx: RTL and testbench

- Serial 8N1 receiver; the stage directly upstream of the begin/end block checker.
- Converts an asynchronous serial line into one ASCII byte per frame, with a one-cycle valid strobe and a framing-error strobe.
- Downstream consumes `out_char` only on cycles where `out_valid` is 1.
- Single clock domain. The line is oversampled at `CLKS_PER_BIT` clocks per bit.

---
 rtl/uart_char_rx.sv | 159 +++++++++++++++
 tb/tb_uart_char_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_char_rx.sv
// ---------------------------------------------------------------------------
// uart_char_rx
//
// Serial 8N1 receiver feeding the begin/end block checker. The raw line is
// brought into the clock domain through a two-flop synchronizer and then
// decoded by a small state machine that samples each bit at its centre.
// CLKS_PER_BIT clock cycles make up one serial bit.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous reset, active low (0 = in reset)
//   rxd        in   1  raw serial line, idles high, asynchronous to clk
//   out_char   out  8  last correctly received byte, held between frames
//   out_valid  out  1  one-cycle pulse: out_char was updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit was sampled low
//
// Optional feature:
//   UART_RX_LOWERCASE_EN  when defined, bytes 'A'..'Z' are folded to
//                         lower case before being loaded into out_char.
//                         When undefined, no folding logic exists.
// ---------------------------------------------------------------------------
module uart_char_rx #(
  parameter  int CLKS_PER_BIT = 16,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] out_char,
  output logic       out_valid,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rxState_e;

  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic             rxdMeta_q;
  logic             rxdSync_q;
  rxState_e         state_q;
  logic [CNT_W-1:0] count_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic [7:0]       outChar_q;
  logic             outValid_q;
  logic             frameErr_q;
  logic [7:0]       rxByte;

  // The line idles high, so the synchronizer resets to 1 to avoid a false
  // start bit right after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxdMeta_q <= 1'b1;
      rxdSync_q <= 1'b1;
    end else begin
      rxdMeta_q <= rxd;
      rxdSync_q <= rxdMeta_q;
    end
  end

  // Value that gets loaded into out_char at a good stop bit.
`ifdef UART_RX_LOWERCASE_EN
  assign rxByte = ((shift_q >= 8'h41) && (shift_q <= 8'h5A)) ? (shift_q + 8'h20) : shift_q;
`else
  assign rxByte = shift_q;
`endif

  // Frame decoder. The start bit is re-checked half a bit after the falling
  // edge so that short glitches are rejected; from that centre point every
  // further sample is exactly one bit period later. The counter restarts at
  // each sample point. Strobes default low every cycle so they last exactly
  // one cycle. BREAK holds off re-arming until the line returns high, so a
  // stuck-low line cannot be decoded as a stream of zero bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      outChar_q  <= '0;
      outValid_q <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      outValid_q <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxdSync_q) begin
            state_q <= S_START;
            count_q <= '0;
          end
        end
        S_START: begin
          if (count_q == CNT_MID) begin
            count_q <= '0;
            if (!rxdSync_q) begin
              state_q  <= S_DATA;
              bitIdx_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        S_DATA: begin
          if (count_q == CNT_MAX) begin
            count_q <= '0;
            shift_q <= {rxdSync_q, shift_q[7:1]};
            if (bitIdx_q == 3'd7) begin
              state_q  <= S_STOP;
              bitIdx_q <= '0;
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        S_STOP: begin
          if (count_q == CNT_MAX) begin
            count_q <= '0;
            if (rxdSync_q) begin
              outChar_q  <= rxByte;
              outValid_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= S_BREAK;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxdSync_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign out_char  = outChar_q;
  assign out_valid = outValid_q;
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_uart_char_rx.sv
module tb_uart_char_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] out_char;
   logic       out_valid;
   logic       frame_err;

   typedef struct packed {
      logic       isErr;
      logic [7:0] ch;
   } expEntry_t;

   expEntry_t  sbQ[$];
   int         checks = 0;
   int         failures = 0;
   int         cycleCount = 0;
   bit         measureLat = 1'b0;
   int         startEdge = 0;
   logic [7:0] lastExp = 8'h00;
   logic [7:0] stream [8] = '{8'h68, 8'h69, 8'h20, 8'h62, 8'h65, 8'h67, 8'h69, 8'h6E};

   uart_char_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .reset(reset),
      .rxd(rxd),
      .out_char(out_char),
      .out_valid(out_valid),
      .frame_err(frame_err)
   );

   // Free-running clock and edge counter used for latency measurement
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
   end

   // Reference model of what the receiver should present for a sent byte
   function automatic logic [7:0] foldChar(input logic [7:0] c);
`ifdef UART_RX_LOWERCASE_EN
      if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
`endif
      return c;
   endfunction

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic pushValid(input logic [7:0] c);
      sbQ.push_back('{isErr: 1'b0, ch: foldChar(c)});
      lastExp = foldChar(c);
   endtask

   task automatic pushErr();
      sbQ.push_back('{isErr: 1'b1, ch: lastExp});
   endtask

   task automatic bitHold(input logic value, input int cycles);
      rxd = value;
      repeat (cycles) @(negedge clk);
   endtask

   // Sends one 8N1 frame, LSB first, with a selectable stop-bit level
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      bitHold(1'b0, CPB);
      for (int i = 0; i < 8; i++) bitHold(data[i], CPB);
      bitHold(stopBit, CPB);
   endtask

   // Waits a bounded time for all expected strobes to be consumed
   task automatic waitDrain(input string name, input int budget);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, sbQ.size(), 0);
   endtask

   // Monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (reset && (out_valid || frame_err)) begin
         expEntry_t e;
         checkOutput("strobe_exclusive", int'(out_valid && frame_err), 0);
         checkOutput("strobe_expected", int'(sbQ.size() != 0), 1);
         if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("strobe_kind", int'(frame_err), int'(e.isErr));
            checkOutput(e.isErr ? "held_char" : "rx_char", out_char, e.ch);
         end
         if (measureLat && out_valid) begin
            measureLat = 1'b0;
            checkOutput("latency_in_range",
                        int'((cycleCount - startEdge) >= 153 && (cycleCount - startEdge) <= 155), 1);
         end
      end
   end

   initial begin
      // Reset and idle
      repeat (3) @(negedge clk);
      checkOutput("reset_out_char", out_char, 8'h00);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_frame_err", frame_err, 0);
      reset = 1'b1;
      repeat (500) @(negedge clk);
      checkOutput("idle_out_char", out_char, 8'h00);

      // Single frame with latency measurement
      startEdge = cycleCount + 1;
      measureLat = 1'b1;
      pushValid(8'h68);
      applyStimulus(8'h68, 1'b1);
      waitDrain("drain_single", 50);
      checkOutput("latency_seen", int'(measureLat), 0);
      measureLat = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("held_after_single", out_char, 8'h68);

      // Back-to-back stream "hi begin"
      foreach (stream[i]) begin
         pushValid(stream[i]);
         applyStimulus(stream[i], 1'b1);
      end
      waitDrain("drain_stream", 50);
      checkOutput("stream_last", out_char, 8'h6E);

      // Short glitch: no strobe expected
      bitHold(1'b0, 4);
      bitHold(1'b1, 60);
      checkOutput("glitch_out_char", out_char, 8'h6E);

      // Framing error followed by a held-low line
      pushErr();
      applyStimulus(8'h41, 1'b0);
      bitHold(1'b0, 200);
      waitDrain("drain_frame_err", 10);
      checkOutput("frame_err_held", out_char, 8'h6E);
      bitHold(1'b1, 40);

      // Reset during data bit 4 of 0x62
      bitHold(1'b0, CPB);
      for (int i = 0; i < 4; i++) bitHold(stream[3][i], CPB);
      bitHold(stream[3][4], CPB / 2);
      reset = 1'b0;
      rxd = 1'b1;
      lastExp = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("midreset_out_char", out_char, 8'h00);
      checkOutput("midreset_out_valid", out_valid, 0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      pushValid(8'h65);
      applyStimulus(8'h65, 1'b1);
      waitDrain("drain_after_reset", 50);
      checkOutput("after_reset_char", out_char, 8'h65);

      // Case folding of 'E'
      pushValid(8'h45);
      applyStimulus(8'h45, 1'b1);
      waitDrain("drain_fold", 50);
`ifdef UART_RX_LOWERCASE_EN
      checkOutput("fold_char", out_char, 8'h65);
`else
      checkOutput("fold_char", out_char, 8'h45);
`endif
      repeat (100) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
